matmul_res_collector: RTL and testbench
=======================================

Name: matmul_res_collector

Overview:
- APB-master readout engine that drains the matmul DUT's result region after a computation completes.
- Assembles the N×M result matrix into a flat register image for the golden comparator.
- Pulses the comparator's compare strobe once the matrix is complete.
- Sits between the DUT's APB slave port and the comparison side of the verification environment; it is the producer end of the start_cmp / mat_res_actual handshake.

Parameters:
- DATA_WIDTH, 8, operand element width in bits.
- BUS_WIDTH, 16, APB data width; each result element occupies one full bus word.
- ADDR_WIDTH, 16, APB address width.
- RES_BASE, 16'h0100, APB word address of result element [0][0].
- MAX_DIM, BUS_WIDTH/DATA_WIDTH, maximum matrix dimension (derived; not to be overridden).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to begin readout; ignored while busy.
- n_dim  in  $clog2(MAX_DIM)+1  result rows N, valid range 1..MAX_DIM; sampled on accepted start.
- m_dim  in  $clog2(MAX_DIM)+1  result columns M, valid range 1..MAX_DIM; sampled on accepted start.
- busy  out  1  high from the cycle after an accepted start until the cycle of done.
- psel  out  1  APB select.
- penable  out  1  APB enable.
- pwrite  out  1  tied 0 (reads only).
- paddr  out  ADDR_WIDTH  APB address.
- prdata  in  BUS_WIDTH  APB read data.
- pready  in  1  APB ready.
- pslverr  in  1  APB slave error.
- mat_res_flat  out  MAX_DIM*MAX_DIM*BUS_WIDTH  element [i][j] at bits [(i*MAX_DIM+j)*BUS_WIDTH +: BUS_WIDTH].
- start_cmp  out  1  one-cycle pulse: matrix complete and error-free.
- rd_err  out  1  sticky error flag; cleared on the next accepted start.

Behaviour:
- Reset values: every output is 0, mat_res_flat is all zeros, and the FSM is in IDLE. Reset is asynchronous; asserting it mid-transfer aborts immediately, with no start_cmp and no completion of the APB transfer.
- FSM states: IDLE, SETUP, ACCESS, NEXT, DONE.
- IDLE:
  - start=1 latches n_dim and m_dim, clears i and j to 0, clears rd_err, and moves to SETUP.
  - If n_dim or m_dim is 0 or greater than MAX_DIM, the block goes straight to DONE with rd_err=1.
- SETUP (1 cycle): psel=1, penable=0, paddr = RES_BASE + i*MAX_DIM + j. Next state is ACCESS.
- ACCESS: psel=1, penable=1, paddr held stable. The block waits for pready=1.
  - On pready=1 with pslverr=0: element [i][j] of mat_res_flat is written with prdata. Next state is NEXT.
  - On pready=1 with pslverr=1: the element is not written, rd_err is set, and the block goes to DONE (remaining elements are skipped).
- NEXT (1 cycle, psel=0):
  - If j==M-1: j=0 and i=i+1; otherwise j=j+1.
  - If the last element (i==N-1, j==M-1) has just been consumed, go to DONE; otherwise go to SETUP.
- DONE (1 cycle):
  - start_cmp=1 if rd_err==0; otherwise start_cmp stays 0.
  - busy drops in this cycle. Next state is IDLE.
- Timing: minimum per element is 3 cycles (SETUP, ACCESS with zero wait, NEXT). Total cycles from start to DONE = 3·N·M + 1 + wait states.
- Elements outside the N×M window retain their previous values; they are not cleared on start.
- A start pulse while busy is ignored. A start in the same cycle as DONE is also ignored; a new start is accepted only in IDLE.
- psel is never asserted outside SETUP and ACCESS. penable=1 only in ACCESS.

Optional Feature:
- Macro: MATMUL_COLLECT_TIMEOUT_EN.
- When defined:
  - An 8-bit wait counter runs in ACCESS, reset on entry to SETUP.
  - If it reaches 255 with pready still 0, the block sets rd_err and goes to DONE (no start_cmp).
  - psel and penable drop in the following cycle.
- When undefined: ACCESS waits indefinitely and no counter is instantiated.

Decomposition:
- matmul_pkg gains:
  - collector state enum typedef (IDLE/SETUP/ACCESS/NEXT/DONE);
  - RES_BASE default constant;
  - TIMEOUT_CYCLES=255 constant.
- DATA_WIDTH and BUS_WIDTH come from the existing package.
- One natural sub-module: matmul_res_idx_cnt, the i/j row-column counter with last-element detect. The APB FSM and data capture stay in the top.

Test Plan:
- N=M=2, zero-wait slave returning 16'h0011, 16'h0022, 16'h0033, 16'h0044. Expected:
  - paddr sequence 0x0100, 0x0101, 0x0102, 0x0103 (MAX_DIM=2);
  - elements [0][0]..[1][1] equal those values;
  - start_cmp pulses once 13 cycles after start; rd_err=0.
- N=1, M=2 with pready delayed 3 cycles per access. Expected:
  - paddr and psel stable throughout each wait;
  - start_cmp at cycle 3·2+1+6=13 after start;
  - [1][*] unchanged.
- pslverr=1 on the second element of a 2×2 readout. Expected:
  - rd_err=1, no start_cmp, busy low after DONE;
  - only element [0][0] updated.
- start asserted again mid-readout and in the DONE cycle. Expected: ignored; exactly one start_cmp pulse; n_dim and m_dim changes ignored.
- rst_n asserted low while in ACCESS. Expected: psel, penable, busy, start_cmp and rd_err go to 0 asynchronously and mat_res_flat is zeroed. A subsequent start with N=M=1 completes normally.
- With MATMUL_COLLECT_TIMEOUT_EN defined and pready held 0: rd_err=1 after 255 ACCESS cycles, no start_cmp, FSM returns to IDLE.

Source files
------------

// File: rtl/matmul_pkg.sv
// Shared matmul definitions: bus geometry, result-region base and the
// result-collector state encoding.
package matmul_pkg;

    localparam int MM_DATA_WIDTH = 8;
    localparam int MM_BUS_WIDTH  = 16;
    localparam int MM_ADDR_WIDTH = 16;

    // APB word address of result element [0][0]
    localparam logic [15:0] MM_RES_BASE = 16'h0100;

    // ACCESS cycles tolerated before a readout is abandoned (timeout build)
    localparam int TIMEOUT_CYCLES = 255;

    typedef enum logic [2:0] {
        COL_IDLE,
        COL_SETUP,
        COL_ACCESS,
        COL_NEXT,
        COL_DONE
    } col_state_e;

endpackage

// File: rtl/matmul_res_idx_cnt.sv
// Row/column walker over the N x M result window, row-major, with
// last-element detect and a look-ahead of the following index.
module matmul_res_idx_cnt #(
    parameter int MAX_DIM = 2,
    parameter int DIM_W   = $clog2(MAX_DIM) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adv,
    input  logic [DIM_W-1:0] n_dim,
    input  logic [DIM_W-1:0] m_dim,
    output logic [DIM_W-1:0] i_idx,
    output logic [DIM_W-1:0] j_idx,
    output logic [DIM_W-1:0] i_nxt,
    output logic [DIM_W-1:0] j_nxt,
    output logic             last
);

    logic col_end;

    // Next index in row-major order and end-of-window detect
    always_comb begin
        col_end = (j_idx == m_dim - DIM_W'(1));
        last    = col_end && (i_idx == n_dim - DIM_W'(1));
        j_nxt   = col_end ? '0 : j_idx + DIM_W'(1);
        i_nxt   = col_end ? i_idx + DIM_W'(1) : i_idx;
    end

    // Index registers: cleared on a new readout, stepped once per element
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i_idx <= '0;
            j_idx <= '0;
        end else if (clr) begin
            i_idx <= '0;
            j_idx <= '0;
        end else if (adv) begin
            i_idx <= i_nxt;
            j_idx <= j_nxt;
        end
    end

endmodule

// File: rtl/matmul_res_collector.sv
// APB-master readout of the matmul result region into a flat matrix image,
// strobing start_cmp once a complete, error-free matrix is held.
// Optional: define MATMUL_COLLECT_TIMEOUT_EN to abandon an ACCESS phase
// that has waited TIMEOUT_CYCLES cycles without pready.
module matmul_res_collector
    import matmul_pkg::*;
#(
    parameter int DATA_WIDTH = MM_DATA_WIDTH,
    parameter int BUS_WIDTH  = MM_BUS_WIDTH,
    parameter int ADDR_WIDTH = MM_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RES_BASE = ADDR_WIDTH'(MM_RES_BASE),
    parameter int MAX_DIM    = BUS_WIDTH / DATA_WIDTH,
    localparam int DIM_W     = $clog2(MAX_DIM) + 1
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 start,
    input  logic [DIM_W-1:0]                     n_dim,
    input  logic [DIM_W-1:0]                     m_dim,
    output logic                                 busy,
    output logic                                 psel,
    output logic                                 penable,
    output logic                                 pwrite,
    output logic [ADDR_WIDTH-1:0]                paddr,
    input  logic [BUS_WIDTH-1:0]                 prdata,
    input  logic                                 pready,
    input  logic                                 pslverr,
    output logic [MAX_DIM*MAX_DIM*BUS_WIDTH-1:0] mat_res_flat,
    output logic                                 start_cmp,
    output logic                                 rd_err
);

    localparam int ELEM_W = (MAX_DIM > 1) ? $clog2(MAX_DIM * MAX_DIM) : 1;

    col_state_e state;
    logic [DIM_W-1:0] n_q, m_q;
    logic [DIM_W-1:0] i_idx, j_idx, i_nxt, j_nxt;
    logic             last;
    logic             dims_bad;
    logic             timeout;
    logic [ELEM_W-1:0] elem_idx;
    logic [MAX_DIM*MAX_DIM-1:0][BUS_WIDTH-1:0] res_q;

    assign pwrite       = 1'b0;
    assign mat_res_flat = res_q;

    function automatic logic [ADDR_WIDTH-1:0] elem_addr(input logic [DIM_W-1:0] r,
                                                        input logic [DIM_W-1:0] c);
        return RES_BASE + ADDR_WIDTH'(r) * ADDR_WIDTH'(MAX_DIM) + ADDR_WIDTH'(c);
    endfunction

    // Dimension validation and flat slot of the element being read
    always_comb begin
        dims_bad = (n_dim == '0) || (m_dim == '0) ||
                   (n_dim > DIM_W'(MAX_DIM)) || (m_dim > DIM_W'(MAX_DIM));
        elem_idx = ELEM_W'(int'(i_idx) * MAX_DIM + int'(j_idx));
    end

    matmul_res_idx_cnt #(
        .MAX_DIM (MAX_DIM),
        .DIM_W   (DIM_W)
    ) u_idx_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (state == COL_IDLE && start),
        .adv   (state == COL_NEXT),
        .n_dim (n_q),
        .m_dim (m_q),
        .i_idx (i_idx),
        .j_idx (j_idx),
        .i_nxt (i_nxt),
        .j_nxt (j_nxt),
        .last  (last)
    );

`ifdef MATMUL_COLLECT_TIMEOUT_EN
    logic [7:0] wait_cnt;

    assign timeout = !pready && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));

    // Wait-state counter: idle at zero outside ACCESS, so every SETUP restarts it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)                   wait_cnt <= '0;
        else if (state != COL_ACCESS) wait_cnt <= '0;
        else if (!pready)             wait_cnt <= wait_cnt + 8'd1;
    end
`else
    assign timeout = 1'b0;
`endif

    // APB read sequencer with registered bus/handshake outputs and element capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= COL_IDLE;
            n_q       <= '0;
            m_q       <= '0;
            busy      <= 1'b0;
            psel      <= 1'b0;
            penable   <= 1'b0;
            paddr     <= '0;
            start_cmp <= 1'b0;
            rd_err    <= 1'b0;
            res_q     <= '0;
        end else begin
            case (state)
                COL_IDLE: begin
                    start_cmp <= 1'b0;
                    if (start) begin
                        n_q <= n_dim;
                        m_q <= m_dim;
                        if (dims_bad) begin
                            rd_err <= 1'b1;
                            state  <= COL_DONE;
                        end else begin
                            rd_err <= 1'b0;
                            busy   <= 1'b1;
                            psel   <= 1'b1;
                            paddr  <= RES_BASE;
                            state  <= COL_SETUP;
                        end
                    end
                end
                COL_SETUP: begin
                    penable <= 1'b1;
                    state   <= COL_ACCESS;
                end
                COL_ACCESS: begin
                    if (pready) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        if (pslverr) begin
                            rd_err <= 1'b1;
                            busy   <= 1'b0;
                            state  <= COL_DONE;
                        end else begin
                            res_q[elem_idx] <= prdata;
                            state           <= COL_NEXT;
                        end
                    end else if (timeout) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        rd_err  <= 1'b1;
                        busy    <= 1'b0;
                        state   <= COL_DONE;
                    end
                end
                COL_NEXT: begin
                    if (last) begin
                        busy      <= 1'b0;
                        start_cmp <= !rd_err;
                        state     <= COL_DONE;
                    end else begin
                        psel  <= 1'b1;
                        paddr <= elem_addr(i_nxt, j_nxt);
                        state <= COL_SETUP;
                    end
                end
                COL_DONE: begin
                    start_cmp <= 1'b0;
                    state     <= COL_IDLE;
                end
                default: state <= COL_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_matmul_res_collector.sv
// Scoreboard bench for matmul_res_collector: stimulus queues expected APB
// addresses, start_cmp latencies and end-of-readout images; a negedge
// monitor pops and compares whenever the DUT presents them.
module tb_matmul_res_collector;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  n_dim = '0, m_dim = '0;
    logic        busy, psel, penable, pwrite, pready, pslverr, start_cmp, rd_err;
    logic [15:0] paddr, prdata;
    logic [63:0] mat_res_flat;

    matmul_res_collector dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start        (start),
        .n_dim        (n_dim),
        .m_dim        (m_dim),
        .busy         (busy),
        .psel         (psel),
        .penable      (penable),
        .pwrite       (pwrite),
        .paddr        (paddr),
        .prdata       (prdata),
        .pready       (pready),
        .pslverr      (pslverr),
        .mat_res_flat (mat_res_flat),
        .start_cmp    (start_cmp),
        .rd_err       (rd_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        err;
        logic [63:0] mat;
    } res_t;

    logic [15:0] q_addr[$];
    int          q_cmp[$];
    res_t        q_res[$];

    int n_vec = 0, n_err = 0;
    int cyc = 0, start_cyc = 0;

    // APB slave model
    logic [15:0] mem [4];
    int          wait_cfg = 0;
    int          wcnt = 0;
    bit          err_en = 1'b0;
    logic [15:0] err_addr = '0;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (psel && penable && !pready) wcnt <= wcnt + 1;
        else                            wcnt <= 0;
    end

    always_comb begin
        pready  = psel && penable && (wcnt >= wait_cfg);
        prdata  = mem[paddr[1:0]];
        pslverr = pready && err_en && (paddr == err_addr);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s (cycle %0d)", nm, cyc);
    endtask

    // Monitor
    logic [15:0] exp_acc_addr = '0;
    bit          busy_prev = 1'b0;

    always @(negedge clk) begin
        if (!rst_n) begin
            busy_prev = 1'b0;
        end else begin
            if (psel && !penable) begin
                if (q_addr.size() == 0) fail("unexpected_setup");
                else begin
                    exp_acc_addr = q_addr.pop_front();
                    chk("setup_paddr", 64'(paddr), 64'(exp_acc_addr));
                end
            end
            if (psel && penable) chk("access_paddr_stable", 64'(paddr), 64'(exp_acc_addr));
            if (psel) chk("pwrite", 64'(pwrite), '0);
            if (penable && !psel) fail("penable_without_psel");
            if (start_cmp) begin
                if (q_cmp.size() == 0) fail("unexpected_start_cmp");
                else chk("start_cmp_latency", 64'(cyc - start_cyc), 64'(q_cmp.pop_front()));
            end
            if (busy_prev && !busy) begin
                if (q_res.size() == 0) fail("unexpected_busy_fall");
                else begin
                    res_t r;
                    r = q_res.pop_front();
                    chk("done_rd_err", 64'(rd_err), 64'(r.err));
                    chk("done_matrix", mat_res_flat, r.mat);
                end
            end
            busy_prev = busy;
        end
    end

    task automatic issue(input logic [1:0] n, input logic [1:0] m);
        @(posedge clk); #1;
        n_dim = n; m_dim = m; start = 1'b1;
        start_cyc = cyc;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit seen;
        seen = 1'b0;
        for (int t = 0; t < 400; t++) begin
            @(negedge clk);
            if (busy) seen = 1'b1;
            else if (seen) return;
        end
        fail({nm, "_timeout"});
    endtask

    task automatic set_mem(input logic [15:0] a, b, c, d);
        mem[0] = a; mem[1] = b; mem[2] = c; mem[3] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        n_err++;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        bit got;
        set_mem(16'h0, 16'h0, 16'h0, 16'h0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_busy", 64'(busy), '0);
        chk("rst_psel", 64'(psel), '0);
        chk("rst_penable", 64'(penable), '0);
        chk("rst_paddr", 64'(paddr), '0);
        chk("rst_start_cmp", 64'(start_cmp), '0);
        chk("rst_rd_err", 64'(rd_err), '0);
        chk("rst_matrix", mat_res_flat, '0);

        // 2x2, zero wait
        set_mem(16'h0011, 16'h0022, 16'h0033, 16'h0044);
        wait_cfg = 0;
        q_addr.push_back(16'h0100); q_addr.push_back(16'h0101);
        q_addr.push_back(16'h0102); q_addr.push_back(16'h0103);
        q_cmp.push_back(13);
        q_res.push_back('{1'b0, 64'h0044_0033_0022_0011});
        issue(2'd2, 2'd2);
        wait_done("s1");

        // 1x2, three wait states per access; row 1 untouched
        set_mem(16'h00A1, 16'h00A2, 16'hBBBB, 16'hCCCC);
        wait_cfg = 3;
        q_addr.push_back(16'h0100); q_addr.push_back(16'h0101);
        q_cmp.push_back(13);
        q_res.push_back('{1'b0, 64'h0044_0033_00A2_00A1});
        issue(2'd1, 2'd2);
        wait_done("s2");

        // 2x2, slave error on second element
        set_mem(16'h0C01, 16'h0C02, 16'h0C03, 16'h0C04);
        wait_cfg = 0;
        err_en = 1'b1; err_addr = 16'h0101;
        q_addr.push_back(16'h0100); q_addr.push_back(16'h0101);
        q_res.push_back('{1'b1, 64'h0044_0033_00A2_0C01});
        issue(2'd2, 2'd2);
        wait_done("s3");
        err_en = 1'b0;
        repeat (2) @(negedge clk);
        chk("s3_busy_after", 64'(busy), '0);
        chk("s3_rd_err_sticky", 64'(rd_err), 64'(1));

        // 2x1 with stray starts mid-readout and in the DONE cycle
        set_mem(16'h5555, 16'h7777, 16'h6666, 16'h8888);
        q_addr.push_back(16'h0100); q_addr.push_back(16'h0102);
        q_cmp.push_back(7);
        q_res.push_back('{1'b0, 64'h0044_6666_00A2_5555});
        issue(2'd2, 2'd1);
        repeat (3) @(posedge clk);
        #1; n_dim = 2'd1; m_dim = 2'd2; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) @(posedge clk);
        #1; n_dim = 2'd2; m_dim = 2'd2; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (12) @(negedge clk);
        chk("s4_idle_busy", 64'(busy), '0);

        // async reset in the middle of an ACCESS wait
        wait_cfg = 10;
        q_addr.push_back(16'h0100);
        issue(2'd2, 2'd2);
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            @(negedge clk);
            if (psel && penable) got = 1'b1;
        end
        if (!got) fail("s5_access_timeout");
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        chk("arst_psel", 64'(psel), '0);
        chk("arst_penable", 64'(penable), '0);
        chk("arst_busy", 64'(busy), '0);
        chk("arst_start_cmp", 64'(start_cmp), '0);
        chk("arst_rd_err", 64'(rd_err), '0);
        chk("arst_matrix", mat_res_flat, '0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1x1 after reset
        wait_cfg = 0;
        set_mem(16'h0777, 16'h0, 16'h0, 16'h0);
        q_addr.push_back(16'h0100);
        q_cmp.push_back(4);
        q_res.push_back('{1'b0, 64'h0000_0000_0000_0777});
        issue(2'd1, 2'd1);
        wait_done("s6");

        // out-of-range dimensions: straight to DONE with error, no bus traffic
        issue(2'd0, 2'd1);
        repeat (3) @(negedge clk);
        chk("bad_n0_rd_err", 64'(rd_err), 64'(1));
        chk("bad_n0_busy", 64'(busy), '0);
        chk("bad_n0_matrix", mat_res_flat, 64'h0000_0000_0000_0777);
        issue(2'd1, 2'd3);
        repeat (3) @(negedge clk);
        chk("bad_m3_rd_err", 64'(rd_err), 64'(1));
        chk("bad_m3_busy", 64'(busy), '0);

        repeat (5) @(negedge clk);
        chk("addr_queue_drained", 64'(q_addr.size()), '0);
        chk("cmp_queue_drained", 64'(q_cmp.size()), '0);
        chk("res_queue_drained", 64'(q_res.size()), '0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
